// File: rtl/cpu_pkg.sv
// Shared definitions for the multicycle CPU datapath: fetch state encodings and
// default bus widths used by the fetch stage.
package cpu_pkg;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_HOLD = 2'd2
  } fetch_state_t;

  localparam int CPU_ADDR_W  = 16;
  localparam int CPU_INSTR_W = 16;

endpackage

// File: rtl/fetch_timeout_timer.sv
// Cycle counter bounding how long the fetch stage waits for an instruction-memory
// acknowledge; o_expired flags the last permitted wait cycle.
module fetch_timeout_timer #(
  parameter int TIMEOUT = 15
) (
  input  logic i_clock,
  input  logic i_reset,
  input  logic i_clear,
  input  logic i_enable,
  output logic o_expired
);

  localparam int CNT_W = $clog2(TIMEOUT + 1);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(TIMEOUT - 1);

  logic [CNT_W-1:0] r_count;

  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) begin
      r_count <= '0;
    end else if (i_clear) begin
      r_count <= '0;
    end else if (i_enable) begin
      r_count <= r_count + 1'b1;
    end
  end

  assign o_expired = (r_count == LAST);

endmodule

// File: rtl/instruction_fetch.sv
// Fetch stage: latches the PC, runs a req/ack read to instruction memory and holds
// the word until decode consumes it, pulsing pc_increment once per completed fetch.
module instruction_fetch
  import cpu_pkg::*;
#(
  parameter int ADDR_W  = CPU_ADDR_W,
  parameter int INSTR_W = CPU_INSTR_W,
  parameter int TIMEOUT = 15
) (
  input  logic               i_clock,
  input  logic               i_reset,
  input  logic               i_fetch_start,
  input  logic [ADDR_W-1:0]  i_pc_in,
  input  logic               i_flush,
  output logic               o_mem_req,
  output logic [ADDR_W-1:0]  o_mem_addr,
  input  logic               i_mem_ack,
  input  logic [INSTR_W-1:0] i_mem_rdata,
  output logic [INSTR_W-1:0] o_instr_out,
  output logic               o_instr_valid,
  input  logic               i_instr_consume,
  output logic               o_pc_increment,
  output logic               o_fetch_busy,
  output logic               o_fetch_error
);

  fetch_state_t r_state;
  fetch_state_t w_next;

  logic [ADDR_W-1:0]  r_addr;
  logic [INSTR_W-1:0] r_instr;
  logic               r_mem_req;
  logic               r_instr_valid;
  logic               r_pc_inc;
  logic               r_busy;
  logic               r_error;

  logic w_launch;
  logic w_accept;
  logic w_timeout;
  logic w_wait;
  logic w_expired;
  logic w_mem_req_nxt;
  logic w_instr_valid_nxt;
  logic w_pc_inc_nxt;
  logic w_busy_nxt;
  logic w_error_nxt;

  // Flush takes priority over any same-cycle acknowledge or consume.
  assign w_launch  = !i_flush && i_fetch_start &&
                     ((r_state == S_IDLE) || ((r_state == S_HOLD) && i_instr_consume));
  assign w_accept  = (r_state == S_REQ) && !i_flush && i_mem_ack;
  assign w_timeout = (r_state == S_REQ) && !i_flush && !i_mem_ack && w_expired;
  assign w_wait    = (r_state == S_REQ) && !i_flush && !i_mem_ack && !w_expired;

  fetch_timeout_timer #(
    .TIMEOUT (TIMEOUT)
  ) u_timer (
    .i_clock   (i_clock),
    .i_reset   (i_reset),
    .i_clear   (w_launch),
    .i_enable  (w_wait),
    .o_expired (w_expired)
  );

  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE: begin
        if (w_launch) w_next = S_REQ;
      end
      S_REQ: begin
        if (i_flush)        w_next = S_IDLE;
        else if (i_mem_ack) w_next = S_HOLD;
        else if (w_expired) w_next = S_IDLE;
      end
      S_HOLD: begin
        if (i_flush)              w_next = S_IDLE;
        else if (w_launch)        w_next = S_REQ;
        else if (i_instr_consume) w_next = S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
  end

  // Outputs are derived from the next state so that every port is a flop.
  always_comb begin
    w_mem_req_nxt     = (w_next == S_REQ);
    w_instr_valid_nxt = (w_next == S_HOLD);
    w_pc_inc_nxt      = w_accept;
    w_busy_nxt        = (w_next != S_IDLE);
    w_error_nxt       = r_error | w_timeout;
  end

  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) begin
      r_addr        <= '0;
      r_instr       <= '0;
      r_mem_req     <= 1'b0;
      r_instr_valid <= 1'b0;
      r_pc_inc      <= 1'b0;
      r_busy        <= 1'b0;
      r_error       <= 1'b0;
    end else begin
      if (w_launch) r_addr  <= i_pc_in;
      if (w_accept) r_instr <= i_mem_rdata;
      r_mem_req     <= w_mem_req_nxt;
      r_instr_valid <= w_instr_valid_nxt;
      r_pc_inc      <= w_pc_inc_nxt;
      r_busy        <= w_busy_nxt;
      r_error       <= w_error_nxt;
    end
  end

  assign o_mem_req      = r_mem_req;
  assign o_mem_addr     = r_addr;
  assign o_instr_out    = r_instr;
  assign o_instr_valid  = r_instr_valid;
  assign o_pc_increment = r_pc_inc;
  assign o_fetch_busy   = r_busy;
  assign o_fetch_error  = r_error;

endmodule

// File: tb/tb_instruction_fetch.sv
// Directed bench for instruction_fetch with a short memory timeout so that the
// abort path is reachable in a few cycles.
module tb_instruction_fetch;

  localparam int ADDR_W  = 16;
  localparam int INSTR_W = 16;
  localparam int TIMEOUT = 4;

  logic               clk;
  logic               rst;
  logic               fetch_start;
  logic [ADDR_W-1:0]  pc_in;
  logic               flush;
  logic               mem_req;
  logic [ADDR_W-1:0]  mem_addr;
  logic               mem_ack;
  logic [INSTR_W-1:0] mem_rdata;
  logic [INSTR_W-1:0] instr_out;
  logic               instr_valid;
  logic               instr_consume;
  logic               pc_increment;
  logic               fetch_busy;
  logic               fetch_error;

  int n_checks = 0;
  int n_fail   = 0;
  int req_cycles;

  instruction_fetch #(
    .ADDR_W  (ADDR_W),
    .INSTR_W (INSTR_W),
    .TIMEOUT (TIMEOUT)
  ) dut (
    .i_clock         (clk),
    .i_reset         (rst),
    .i_fetch_start   (fetch_start),
    .i_pc_in         (pc_in),
    .i_flush         (flush),
    .o_mem_req       (mem_req),
    .o_mem_addr      (mem_addr),
    .i_mem_ack       (mem_ack),
    .i_mem_rdata     (mem_rdata),
    .o_instr_out     (instr_out),
    .o_instr_valid   (instr_valid),
    .i_instr_consume (instr_consume),
    .o_pc_increment  (pc_increment),
    .o_fetch_busy    (fetch_busy),
    .o_fetch_error   (fetch_error)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Advance one clock and settle just after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1; fetch_start = 1'b0; pc_in = '0; flush = 1'b0;
    mem_ack = 1'b0; mem_rdata = '0; instr_consume = 1'b0;
    #12;
    check("rst_mem_req", 32'(mem_req), 32'h0);
    check("rst_mem_addr", 32'(mem_addr), 32'h0);
    check("rst_instr_out", 32'(instr_out), 32'h0);
    check("rst_valid", 32'(instr_valid), 32'h0);
    check("rst_busy", 32'(fetch_busy), 32'h0);
    check("rst_error", 32'(fetch_error), 32'h0);
    rst = 1'b0;
    tick();

    // 1: basic fetch, ack on the second REQ cycle
    pc_in = 16'h0010; fetch_start = 1'b1;
    tick();
    fetch_start = 1'b0;
    check("t1_req_c1", 32'(mem_req), 32'h1);
    check("t1_addr", 32'(mem_addr), 32'h0010);
    check("t1_busy", 32'(fetch_busy), 32'h1);
    check("t1_no_inc_c1", 32'(pc_increment), 32'h0);
    tick();
    check("t1_req_c2", 32'(mem_req), 32'h1);
    mem_ack = 1'b1; mem_rdata = 16'hA5C3;
    tick();
    mem_ack = 1'b0; mem_rdata = 16'h0000;
    check("t1_instr", 32'(instr_out), 32'hA5C3);
    check("t1_valid", 32'(instr_valid), 32'h1);
    check("t1_inc", 32'(pc_increment), 32'h1);
    check("t1_req_drop", 32'(mem_req), 32'h0);
    tick();
    check("t1_inc_once", 32'(pc_increment), 32'h0);
    check("t1_valid_held", 32'(instr_valid), 32'h1);

    // 2: back-to-back consume + start
    instr_consume = 1'b1; fetch_start = 1'b1; pc_in = 16'h0011;
    tick();
    instr_consume = 1'b0; fetch_start = 1'b0;
    check("t2_req", 32'(mem_req), 32'h1);
    check("t2_addr", 32'(mem_addr), 32'h0011);
    check("t2_valid_drop", 32'(instr_valid), 32'h0);
    check("t2_busy", 32'(fetch_busy), 32'h1);

    // 3: flush beats a same-cycle ack
    flush = 1'b1; mem_ack = 1'b1; mem_rdata = 16'h1234;
    tick();
    flush = 1'b0; mem_ack = 1'b0;
    check("t3_req", 32'(mem_req), 32'h0);
    check("t3_busy", 32'(fetch_busy), 32'h0);
    check("t3_valid", 32'(instr_valid), 32'h0);
    check("t3_inc", 32'(pc_increment), 32'h0);
    check("t3_ir_kept", 32'(instr_out), 32'hA5C3);
    tick();
    check("t3_inc_late", 32'(pc_increment), 32'h0);

    // 4: timeout after exactly TIMEOUT REQ cycles
    pc_in = 16'h0020; fetch_start = 1'b1;
    tick();
    fetch_start = 1'b0;
    req_cycles = mem_req ? 1 : 0;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (!mem_req) break;
      req_cycles++;
    end
    check("t4_req_cycles", 32'(req_cycles), 32'd4);
    check("t4_error", 32'(fetch_error), 32'h1);
    check("t4_busy", 32'(fetch_busy), 32'h0);
    check("t4_no_inc", 32'(pc_increment), 32'h0);
    pc_in = 16'h0030; fetch_start = 1'b1;
    tick();
    fetch_start = 1'b0;
    check("t4_addr2", 32'(mem_addr), 32'h0030);
    mem_ack = 1'b1; mem_rdata = 16'h0F0F;
    tick();
    mem_ack = 1'b0;
    check("t4_instr2", 32'(instr_out), 32'h0F0F);
    check("t4_valid2", 32'(instr_valid), 32'h1);
    check("t4_inc2", 32'(pc_increment), 32'h1);
    check("t4_error_sticky", 32'(fetch_error), 32'h1);
    instr_consume = 1'b1;
    tick();
    instr_consume = 1'b0;
    check("t4_consume_idle", 32'(fetch_busy), 32'h0);
    check("t4_consume_valid", 32'(instr_valid), 32'h0);

    // 5: asynchronous reset in the middle of a REQ cycle
    pc_in = 16'h0040; fetch_start = 1'b1;
    tick();
    fetch_start = 1'b0;
    check("t5_req", 32'(mem_req), 32'h1);
    #2 rst = 1'b1;
    #1;
    check("t5_rst_req", 32'(mem_req), 32'h0);
    check("t5_rst_addr", 32'(mem_addr), 32'h0);
    check("t5_rst_busy", 32'(fetch_busy), 32'h0);
    check("t5_rst_error", 32'(fetch_error), 32'h0);
    check("t5_rst_instr", 32'(instr_out), 32'h0);
    #2 rst = 1'b0;
    mem_ack = 1'b1; mem_rdata = 16'hBEEF;
    tick();
    mem_ack = 1'b0;
    check("t5_ack_ignored_v", 32'(instr_valid), 32'h0);
    check("t5_ack_ignored_i", 32'(instr_out), 32'h0);
    check("t5_ack_ignored_inc", 32'(pc_increment), 32'h0);

    // 6: top-of-memory address, then stray ack and flushed start while idle
    pc_in = 16'hFFFF; fetch_start = 1'b1;
    tick();
    fetch_start = 1'b0;
    check("t6_addr", 32'(mem_addr), 32'hFFFF);
    mem_ack = 1'b1; mem_rdata = 16'h7777;
    tick();
    mem_ack = 1'b0;
    check("t6_inc", 32'(pc_increment), 32'h1);
    check("t6_instr", 32'(instr_out), 32'h7777);
    tick();
    check("t6_inc_once", 32'(pc_increment), 32'h0);
    instr_consume = 1'b1;
    tick();
    instr_consume = 1'b0;
    mem_ack = 1'b1; mem_rdata = 16'h9999;
    tick();
    mem_ack = 1'b0;
    check("t6_stray_valid", 32'(instr_valid), 32'h0);
    check("t6_stray_instr", 32'(instr_out), 32'h7777);
    check("t6_stray_inc", 32'(pc_increment), 32'h0);
    fetch_start = 1'b1; flush = 1'b1; pc_in = 16'h0050;
    tick();
    fetch_start = 1'b0; flush = 1'b0;
    check("t6_flush_start_req", 32'(mem_req), 32'h0);
    check("t6_flush_start_addr", 32'(mem_addr), 32'hFFFF);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
